// File: rtl/mux4_rr_arbiter_pkg.sv
// arb_pkg: shared constants and state type for the 4-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  localparam int DEF_MAX_HOLD = 8;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant/select bundle between requesters and the arbiter.
interface mux4_rr_arbiter_if;
  import arb_pkg::*;
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] grant_o;
  logic [SEL_W-1:0] sel_o;
  logic busy_o;
  modport master (output req_i, input grant_o, sel_o, busy_o);
  modport slave (input req_i, output grant_o, sel_o, busy_o);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin winner search starting after last, optionally skipping mask_idx.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic [1:0] mask_idx,
  input  logic       mask_en,
  output logic       found,
  output logic [1:0] idx
);
  logic [1:0] w_c;
  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    found = 1'b0;
    idx = last;
    w_c = last;
    for (int k = 4; k >= 1; k--) begin
      w_c = last + k[1:0];
      if (req[w_c] && !(mask_en && w_c == mask_idx)) begin
        found = 1'b1;
        idx = w_c;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a 4:1 mux; optional per-owner hold limit via ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter
  import arb_pkg::*;
`ifdef ARB_HOLD_LIMIT_EN
  #(parameter int MAX_HOLD = DEF_MAX_HOLD)
`endif
  (
  input logic clk_i,
  input logic reset_i,
  mux4_rr_arbiter_if.slave arb
);
  arb_state_t r_state, w_state_nxt;
  logic [3:0] r_grant, w_grant_nxt, w_onehot;
  logic [1:0] r_sel, w_sel_nxt, r_last, w_last_nxt, w_idx;
  logic w_found, w_rel, w_force;
`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [8:0] w_cnt_inc;
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_force = arb.req_i[r_sel] && w_cnt_inc >= 9'(MAX_HOLD) && w_found;
`else
  assign w_force = 1'b0;
`endif
  // While granted, search from the owner with the owner masked, so w_found means "someone else waits".
  rr_pick4 u_pick (
    .req(arb.req_i),
    .last(r_state == GRANT ? r_sel : r_last),
    .mask_idx(r_sel),
    .mask_en(r_state == GRANT),
    .found(w_found),
    .idx(w_idx)
  );
  assign w_onehot = 4'b0001 << w_idx;
  assign w_rel = r_state == GRANT && (!arb.req_i[r_sel] || w_force);
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt = r_sel;
    w_last_nxt = r_last;
`ifdef ARB_HOLD_LIMIT_EN
    w_cnt_nxt = r_cnt;
`endif
    if (r_state == IDLE || w_rel) begin
      w_last_nxt = r_state == GRANT ? r_sel : r_last;
      w_state_nxt = w_found ? GRANT : IDLE;
      w_grant_nxt = w_found ? w_onehot : 4'b0000;
      w_sel_nxt = w_found ? w_idx : r_sel;
`ifdef ARB_HOLD_LIMIT_EN
      w_cnt_nxt = 8'd0;
    end else begin
      w_cnt_nxt = w_cnt_inc >= 9'(MAX_HOLD) ? 8'(MAX_HOLD) : w_cnt_inc[7:0];
`endif
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_grant <= 4'b0000;
      r_sel <= 2'd0;
      r_last <= 2'd3;
`ifdef ARB_HOLD_LIMIT_EN
      r_cnt <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel <= w_sel_nxt;
      r_last <= w_last_nxt;
`ifdef ARB_HOLD_LIMIT_EN
      r_cnt <= w_cnt_nxt;
`endif
    end
  end
  assign arb.grant_o = r_grant;
  assign arb.sel_o = r_sel;
  assign arb.busy_o = |r_grant;
endmodule
